// File: rtl/raster_tri_stepper_pkg.sv
// Shared types for the triangle stepper: depth/cull modes, FSM states,
// and the edge-function width helper.
package raster_tri_stepper_pkg;

   typedef enum logic [1:0] {
      Z_LESS   = 2'd0,
      Z_LEQUAL = 2'd1,
      Z_ALWAYS = 2'd2,
      Z_NEVER  = 2'd3
   } zfunc_e;

   typedef enum logic [1:0] {
      CULL_NONE  = 2'd0,
      CULL_BACK  = 2'd1,
      CULL_FRONT = 2'd2,
      CULL_RSVD  = 2'd3
   } cull_e;

   typedef enum logic [3:0] {
      S_IDLE,
      S_SETUP,
      S_INIT,
      S_SCAN,
      S_ZREAD,
      S_ZTEST,
      S_WRITE,
      S_STEP,
      S_FINISH
   } state_e;

   localparam int CW_DEF = 11;
   localparam int EW_DEF = 2 * CW_DEF + 3;

   function automatic int edge_w(input int cw);
      return 2 * cw + 3;
   endfunction

endpackage

// File: rtl/raster_tri_stepper_edge_stepper.sv
// One incremental edge function: value plus x/y step coefficients.
// Load may negate on the way in so clockwise triangles share the >=0 test.
module raster_tri_stepper_edge_stepper
   import raster_tri_stepper_pkg::*;
#(
   parameter int EW = EW_DEF
) (
   input  logic                 i_clk,
   input  logic                 i_areset,
   input  logic                 i_load,
   input  logic                 i_neg,
   input  logic                 i_step_x,
   input  logic                 i_dir,
   input  logic                 i_step_y,
   input  logic signed [EW-1:0] i_e0,
   input  logic signed [EW-1:0] i_cx,
   input  logic signed [EW-1:0] i_cy,
   output logic                 o_inside
);

   logic signed [EW-1:0] r_e;
   logic signed [EW-1:0] r_cx;
   logic signed [EW-1:0] r_cy;

   always_ff @(posedge i_clk) begin
      if (i_areset) begin
         r_e  <= '0;
         r_cx <= '0;
         r_cy <= '0;
      end else if (i_load) begin
         r_e  <= i_neg ? -i_e0 : i_e0;
         r_cx <= i_neg ? -i_cx : i_cx;
         r_cy <= i_neg ? -i_cy : i_cy;
      end else if (i_step_x) begin
         r_e <= i_dir ? r_e + r_cx : r_e - r_cx;
      end else if (i_step_y) begin
         r_e <= r_e + r_cy;
      end else if (i_neg) begin
         r_e  <= -r_e;
         r_cx <= -r_cx;
         r_cy <= -r_cy;
      end
   end

   assign o_inside = ~r_e[EW-1];

endmodule

// File: rtl/raster_tri_stepper.sv
// Integer triangle rasteriser: serpentine bbox walk with incremental
// edge functions, depth test against the z-buffer, framebuffer writes.
module raster_tri_stepper
   import raster_tri_stepper_pkg::*;
#(
   parameter int CW        = 11,
   parameter int SCREEN_W  = 640,
   parameter int SCREEN_H  = 480,
   parameter int XYW       = 10,
   parameter int ZW        = 6,
   parameter int ZF        = 16,
   parameter int COLW      = 4,
   parameter int ZB_RD_LAT = 1
) (
   input  logic                   i_clk,
   input  logic                   i_areset,
   input  logic                   i_start,
   input  logic signed [CW-1:0]   i_v0x,
   input  logic signed [CW-1:0]   i_v0y,
   input  logic signed [CW-1:0]   i_v1x,
   input  logic signed [CW-1:0]   i_v1y,
   input  logic signed [CW-1:0]   i_v2x,
   input  logic signed [CW-1:0]   i_v2y,
   input  logic signed [ZW+ZF:0]  i_z_c,
   input  logic signed [ZW+ZF:0]  i_z_dx,
   input  logic signed [ZW+ZF:0]  i_z_dy,
   input  logic [COLW-1:0]        i_color,
   input  logic [1:0]             i_zfunc,
   input  logic                   i_z_write,
   input  logic [1:0]             i_cull,
   output logic                   o_busy,
   output logic                   o_done,
   output logic                   o_culled,
   output logic [2*XYW-1:0]       o_frag_count,
   output logic                   o_fb_we,
   output logic [XYW-1:0]         o_fb_x,
   output logic [XYW-1:0]         o_fb_y,
   output logic [COLW-1:0]        o_fb_data,
   input  logic                   i_fb_ready,
   output logic                   o_zb_re,
   output logic [XYW-1:0]         o_zb_x,
   output logic [XYW-1:0]         o_zb_y,
   input  logic [ZW-1:0]          i_zb_rdata,
   output logic                   o_zb_we,
   output logic [ZW-1:0]          o_zb_wdata
);

   localparam int EW  = edge_w(CW);
   localparam int ZIW = ZW + ZF + 1;
   localparam int ZAW = ZIW + XYW + 2;
   localparam int WW  = (ZB_RD_LAT > 1) ? $clog2(ZB_RD_LAT) : 1;
   localparam logic signed [CW-1:0] XMAX = CW'(SCREEN_W - 1);
   localparam logic signed [CW-1:0] YMAX = CW'(SCREEN_H - 1);

   state_e r_state, w_next;

   logic signed [CW-1:0]  r_vx [3];
   logic signed [CW-1:0]  r_vy [3];
   logic signed [ZIW-1:0] r_zc, r_zdx, r_zdy;
   logic [COLW-1:0]       r_color;
   zfunc_e                r_zfunc;
   cull_e                 r_cull;
   logic                  r_zwrite;
   logic                  r_neg;
   logic                  r_culled;
   logic [XYW-1:0]        r_lx, r_rx, r_ty, r_by;
   logic [XYW-1:0]        r_x, r_y;
   logic                  r_dir;
   logic signed [ZAW-1:0] r_z;
   logic [WW-1:0]         r_wait;
   logic [2*XYW-1:0]      r_frag;

   logic signed [EW-1:0] w_ex [3];
   logic signed [EW-1:0] w_ey [3];
   logic signed [EW-1:0] w_dx [3];
   logic signed [EW-1:0] w_dy [3];
   logic signed [EW-1:0] w_e0 [3];
   logic signed [EW-1:0] w_px, w_py, w_area;
   logic [2:0]           w_inside;
   logic                 w_load, w_stx, w_sty;
   logic                 w_cull_hit, w_empty, w_xmove, w_pass;

   logic signed [CW-1:0] w_minx, w_maxx, w_miny, w_maxy;
   logic signed [CW-1:0] w_lxc, w_rxc, w_tyc, w_byc;

   logic signed [ZAW-1:0] w_zlx, w_zty, w_zdx, w_zdy, w_z0, w_zsh;
   logic [ZW-1:0]         w_zq;

   assign w_px = EW'(r_lx);
   assign w_py = EW'(r_ty);

   for (genvar g = 0; g < 3; g++) begin : g_edge
      localparam int N = (g + 1) % 3;
      assign w_ex[g] = EW'(r_vx[g]);
      assign w_ey[g] = EW'(r_vy[g]);
      assign w_dx[g] = w_ex[N] - w_ex[g];
      assign w_dy[g] = w_ey[N] - w_ey[g];
      assign w_e0[g] = (w_py - w_ey[g]) * w_dx[g]
                     - (w_px - w_ex[g]) * w_dy[g];

      raster_tri_stepper_edge_stepper #(.EW(EW)) u_edge (
         .i_clk    (i_clk),
         .i_areset (i_areset),
         .i_load   (w_load),
         .i_neg    (w_load & r_neg),
         .i_step_x (w_stx),
         .i_dir    (r_dir),
         .i_step_y (w_sty),
         .i_e0     (w_e0[g]),
         .i_cx     (-w_dy[g]),
         .i_cy     (w_dx[g]),
         .o_inside (w_inside[g])
      );
   end

   // area = dX0*(v2y-v0y) - (v2x-v0x)*dY0, with v2-v0 == -d2
   assign w_area = w_dy[0] * w_dx[2] - w_dx[0] * w_dy[2];

   always_comb begin
      w_minx = r_vx[0];
      w_maxx = r_vx[0];
      w_miny = r_vy[0];
      w_maxy = r_vy[0];
      for (int i = 1; i < 3; i++) begin
         if (r_vx[i] < w_minx) w_minx = r_vx[i];
         if (r_vx[i] > w_maxx) w_maxx = r_vx[i];
         if (r_vy[i] < w_miny) w_miny = r_vy[i];
         if (r_vy[i] > w_maxy) w_maxy = r_vy[i];
      end
      w_lxc = w_minx[CW-1] ? '0 : w_minx;
      w_tyc = w_miny[CW-1] ? '0 : w_miny;
      w_rxc = (w_maxx > XMAX) ? XMAX : w_maxx;
      w_byc = (w_maxy > YMAX) ? YMAX : w_maxy;
   end

   assign w_empty    = (w_lxc > w_rxc) || (w_tyc > w_byc);
   assign w_cull_hit = (w_area == '0)
                    || (r_cull == CULL_BACK && w_area[EW-1])
                    || (r_cull == CULL_FRONT && !w_area[EW-1]);

   assign w_zlx = ZAW'(r_lx);
   assign w_zty = ZAW'(r_ty);
   assign w_zdx = ZAW'(r_zdx);
   assign w_zdy = ZAW'(r_zdy);
   assign w_z0  = ZAW'(r_zc) + w_zdx * w_zlx + w_zdy * w_zty;
   assign w_zsh = r_z >>> ZF;

   always_comb begin
      w_zq = w_zsh[ZW-1:0];
      if (w_zsh[ZAW-1])
         w_zq = '0;
      else if (w_zsh > ZAW'((1 << ZW) - 1))
         w_zq = '1;
   end

   always_comb begin
      w_pass = 1'b0;
      unique case (r_zfunc)
         Z_LESS:   w_pass = w_zq < i_zb_rdata;
         Z_LEQUAL: w_pass = w_zq <= i_zb_rdata;
         Z_ALWAYS: w_pass = 1'b1;
         Z_NEVER:  w_pass = 1'b0;
      endcase
   end

   assign w_xmove = r_dir ? (r_x < r_rx) : (r_x > r_lx);

   always_ff @(posedge i_clk) begin
      if (i_areset) r_state <= S_IDLE;
      else          r_state <= w_next;
   end

   always_comb begin
      w_next   = r_state;
      o_busy   = 1'b1;
      o_done   = 1'b0;
      o_culled = 1'b0;
      o_fb_we  = 1'b0;
      o_zb_re  = 1'b0;
      o_zb_we  = 1'b0;
      w_load   = 1'b0;
      w_stx    = 1'b0;
      w_sty    = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            o_busy = 1'b0;
            if (i_start) w_next = S_SETUP;
         end
         S_SETUP: begin
            if (w_cull_hit || w_empty) w_next = S_FINISH;
            else                       w_next = S_INIT;
         end
         S_INIT: begin
            w_load = 1'b1;
            w_next = S_SCAN;
         end
         S_SCAN: begin
            if (&w_inside) w_next = S_ZREAD;
            else           w_next = S_STEP;
         end
         S_ZREAD: begin
            o_zb_re = (r_wait == '0);
            if (r_wait == WW'(ZB_RD_LAT - 1)) w_next = S_ZTEST;
         end
         S_ZTEST: begin
            o_zb_we = w_pass & r_zwrite;
            w_next  = w_pass ? S_WRITE : S_STEP;
         end
         S_WRITE: begin
            o_fb_we = 1'b1;
            if (i_fb_ready) w_next = S_STEP;
         end
         S_STEP: begin
            if (w_xmove)          w_stx  = 1'b1;
            else if (r_y != r_by) w_sty  = 1'b1;
            if (!w_xmove && r_y == r_by) w_next = S_FINISH;
            else                         w_next = S_SCAN;
         end
         S_FINISH: begin
            o_busy   = 1'b0;
            o_done   = 1'b1;
            o_culled = r_culled;
            w_next   = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_areset) begin
         for (int i = 0; i < 3; i++) begin
            r_vx[i] <= '0;
            r_vy[i] <= '0;
         end
         r_zc     <= '0;
         r_zdx    <= '0;
         r_zdy    <= '0;
         r_color  <= '0;
         r_zfunc  <= Z_LESS;
         r_cull   <= CULL_NONE;
         r_zwrite <= 1'b0;
         r_neg    <= 1'b0;
         r_culled <= 1'b0;
         r_lx     <= '0;
         r_rx     <= '0;
         r_ty     <= '0;
         r_by     <= '0;
         r_x      <= '0;
         r_y      <= '0;
         r_dir    <= 1'b1;
         r_z      <= '0;
         r_wait   <= '0;
         r_frag   <= '0;
      end else begin
         case (r_state)
            S_IDLE: if (i_start) begin
               r_vx[0]  <= i_v0x;
               r_vy[0]  <= i_v0y;
               r_vx[1]  <= i_v1x;
               r_vy[1]  <= i_v1y;
               r_vx[2]  <= i_v2x;
               r_vy[2]  <= i_v2y;
               r_zc     <= i_z_c;
               r_zdx    <= i_z_dx;
               r_zdy    <= i_z_dy;
               r_color  <= i_color;
               r_zfunc  <= zfunc_e'(i_zfunc);
               r_cull   <= cull_e'(i_cull);
               r_zwrite <= i_z_write;
               r_culled <= 1'b0;
               r_frag   <= '0;
            end
            S_SETUP: begin
               r_neg    <= w_area[EW-1];
               r_culled <= w_cull_hit;
               r_lx     <= XYW'(w_lxc);
               r_rx     <= XYW'(w_rxc);
               r_ty     <= XYW'(w_tyc);
               r_by     <= XYW'(w_byc);
            end
            S_INIT: begin
               r_x   <= r_lx;
               r_y   <= r_ty;
               r_dir <= 1'b1;
               r_z   <= w_z0;
            end
            S_SCAN:  r_wait <= '0;
            S_ZREAD: r_wait <= r_wait + 1'b1;
            S_WRITE: if (i_fb_ready) r_frag <= r_frag + 1'b1;
            S_STEP: begin
               if (w_xmove) begin
                  r_x <= r_dir ? r_x + 1'b1 : r_x - 1'b1;
                  r_z <= r_dir ? r_z + w_zdx : r_z - w_zdx;
               end else if (r_y != r_by) begin
                  r_y   <= r_y + 1'b1;
                  r_dir <= ~r_dir;
                  r_z   <= r_z + w_zdy;
               end
            end
            default: ;
         endcase
      end
   end

   assign o_frag_count = r_frag;
   assign o_fb_x       = r_x;
   assign o_fb_y       = r_y;
   assign o_fb_data    = r_color;
   assign o_zb_x       = r_x;
   assign o_zb_y       = r_y;
   assign o_zb_wdata   = w_zq;

endmodule

// File: tb/tb_raster_tri_stepper.sv
// Directed bench for raster_tri_stepper: vector table of small triangles
// plus hand sequences for back-pressure and mid-triangle reset.
module tb_raster_tri_stepper;
   import raster_tri_stepper_pkg::*;

   localparam int CW   = 11;
   localparam int XYW  = 10;
   localparam int ZW   = 6;
   localparam int ZF   = 16;
   localparam int COLW = 4;
   localparam int ZIW  = ZW + ZF + 1;

   logic clk = 1'b0;
   logic areset, start;
   logic signed [CW-1:0]  v0x, v0y, v1x, v1y, v2x, v2y;
   logic signed [ZIW-1:0] z_c, z_dx, z_dy;
   logic [COLW-1:0]       color;
   logic [1:0]            zfunc, cull;
   logic                  z_write;
   logic                  busy, done, culled;
   logic [2*XYW-1:0]      frag_count;
   logic                  fb_we, fb_ready, zb_re, zb_we;
   logic [XYW-1:0]        fb_x, fb_y, zb_x, zb_y;
   logic [COLW-1:0]       fb_data;
   logic [ZW-1:0]         zb_rdata, zb_wdata;

   always #5 clk = ~clk;

   raster_tri_stepper dut (
      .i_clk(clk), .i_areset(areset), .i_start(start),
      .i_v0x(v0x), .i_v0y(v0y), .i_v1x(v1x), .i_v1y(v1y),
      .i_v2x(v2x), .i_v2y(v2y),
      .i_z_c(z_c), .i_z_dx(z_dx), .i_z_dy(z_dy),
      .i_color(color), .i_zfunc(zfunc), .i_z_write(z_write),
      .i_cull(cull),
      .o_busy(busy), .o_done(done), .o_culled(culled),
      .o_frag_count(frag_count),
      .o_fb_we(fb_we), .o_fb_x(fb_x), .o_fb_y(fb_y),
      .o_fb_data(fb_data), .i_fb_ready(fb_ready),
      .o_zb_re(zb_re), .o_zb_x(zb_x), .o_zb_y(zb_y),
      .i_zb_rdata(zb_rdata),
      .o_zb_we(zb_we), .o_zb_wdata(zb_wdata)
   );

   typedef struct {
      int ax, ay, bx, by, cx, cy;
      int zf, cul, zw;
      int zc, zdx;
      int zrd, col;
      int efb, ezb, eculled, ezq;
   } vec_t;

   int n_tests = 0;
   int n_fail  = 0;
   int n_fb = 0, n_zb = 0, n_bad = 0, n_zbad = 0;
   int hits [16];
   int cur_color = 0;
   int cur_zexp  = 0;

   function automatic bit in_tri(input int x, input int y);
      return (x + y) <= 3;
   endfunction

   initial for (int i = 0; i < 16; i++) hits[i] = 0;

   always @(negedge clk) begin
      if (!areset && fb_we && fb_ready) begin
         n_fb++;
         if (!in_tri(int'(fb_x), int'(fb_y)) || int'(fb_data) != cur_color)
            n_bad++;
         else
            hits[int'(fb_y) * 4 + int'(fb_x)]++;
      end
      if (!areset && zb_we) begin
         n_zb++;
         if (!in_tri(int'(zb_x), int'(zb_y)) || int'(zb_wdata) != cur_zexp)
            n_zbad++;
      end
   end

   task automatic chk(input string name, input longint act, input longint exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic apply(input vec_t v);
      v0x = CW'(v.ax); v0y = CW'(v.ay);
      v1x = CW'(v.bx); v1y = CW'(v.by);
      v2x = CW'(v.cx); v2y = CW'(v.cy);
      z_c  = ZIW'(v.zc)  <<< ZF;
      z_dx = ZIW'(v.zdx) <<< ZF;
      z_dy = '0;
      zfunc    = 2'(v.zf);
      cull     = 2'(v.cul);
      z_write  = v.zw[0];
      zb_rdata = ZW'(v.zrd);
      color    = COLW'(v.col);
      cur_color = v.col;
      cur_zexp  = v.ezq;
   endtask

   // Waits for done within a cycle budget; returns culled/busy seen with it.
   task automatic wait_done(output bit seen, output bit c, output bit b);
      seen = 0; c = 0; b = 1;
      for (int i = 0; i < 400 && !seen; i++) begin
         @(posedge clk); #1;
         if (done) begin
            seen = 1; c = culled; b = busy;
         end
      end
   endtask

   task automatic run(input vec_t v, input string tag);
      int b_fb, b_zb, b_bad, b_zbad, perr, ex;
      int b_hits [16];
      bit seen, c, b;
      apply(v);
      b_fb = n_fb; b_zb = n_zb; b_bad = n_bad; b_zbad = n_zbad;
      for (int i = 0; i < 16; i++) b_hits[i] = hits[i];
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      wait_done(seen, c, b);
      @(posedge clk); #1;
      chk({tag, " done"}, longint'(seen), 1);
      chk({tag, " culled"}, longint'(c), longint'(v.eculled));
      chk({tag, " busy_at_done"}, longint'(b), 0);
      chk({tag, " frag_count"}, longint'(frag_count), longint'(v.efb));
      chk({tag, " fb_writes"}, n_fb - b_fb, v.efb);
      chk({tag, " zb_writes"}, n_zb - b_zb, v.ezb);
      chk({tag, " fb_bad"}, n_bad - b_bad, 0);
      chk({tag, " zb_bad"}, n_zbad - b_zbad, 0);
      perr = 0;
      for (int y = 0; y < 4; y++)
         for (int x = 0; x < 4; x++) begin
            ex = (v.efb == 10 && in_tri(x, y)) ? 1 : 0;
            if (hits[y*4+x] - b_hits[y*4+x] != ex) perr++;
         end
      chk({tag, " pixel_map"}, perr, 0);
   endtask

   function automatic vec_t mk(input int ax, ay, bx, by, cx, cy,
                               input int zf, cul, zw, zc, zdx, zrd,
                               input int efb, ezb, ecul, ezq);
      vec_t v;
      v.ax = ax; v.ay = ay; v.bx = bx; v.by = by; v.cx = cx; v.cy = cy;
      v.zf = zf; v.cul = cul; v.zw = zw; v.zc = zc; v.zdx = zdx;
      v.zrd = zrd; v.col = 5;
      v.efb = efb; v.ezb = ezb; v.eculled = ecul; v.ezq = ezq;
      return v;
   endfunction

   vec_t vt [12];

   initial begin
      int b_fb, b_hold;
      int perr;
      int b_hits [16];
      bit seen, c, b, found, stable;
      logic [XYW-1:0]  sx, sy;
      logic [COLW-1:0] sd;

      //       ax ay bx by cx cy  zf cul zw  zc zdx zrd  fb  zb cul zq
      vt[0]  = mk(0, 0, 3, 0, 0, 3, 2, 0, 1,  0,  0,  0, 10, 10, 0,  0);
      vt[1]  = mk(0, 0, 3, 0, 0, 3, 0, 0, 1, 10,  0, 20, 10, 10, 0, 10);
      vt[2]  = mk(0, 0, 3, 0, 0, 3, 0, 0, 1, 10,  0, 10,  0,  0, 0, 10);
      vt[3]  = mk(0, 0, 3, 0, 0, 3, 1, 0, 1, 10,  0, 10, 10, 10, 0, 10);
      vt[4]  = mk(0, 0, 0, 3, 3, 0, 2, 1, 1,  0,  0,  0,  0,  0, 1,  0);
      vt[5]  = mk(0, 0, 0, 3, 3, 0, 2, 0, 1, 10,  0,  0, 10, 10, 0, 10);
      vt[6]  = mk(0, 0, 2, 2, 4, 4, 2, 0, 1,  0,  0,  0,  0,  0, 1,  0);
      vt[7]  = mk(-10,0,-5, 0,-10,5, 2, 0, 1,  0,  0,  0,  0,  0, 0,  0);
      vt[8]  = mk(0, 0, 3, 0, 0, 3, 2, 2, 1,  0,  0,  0,  0,  0, 1,  0);
      vt[9]  = mk(0, 0, 3, 0, 0, 3, 3, 0, 1,  0,  0, 63,  0,  0, 0,  0);
      vt[10] = mk(0, 0, 3, 0, 0, 3, 0, 0, 0, 10,  0, 20, 10,  0, 0, 10);
      vt[11] = mk(0, 0, 3, 0, 0, 3, 2, 0, 1, 63,  1,  0, 10, 10, 0, 63);

      areset = 1'b1; start = 1'b0; fb_ready = 1'b1;
      apply(vt[0]);
      repeat (3) @(posedge clk);
      #1;
      chk("rst busy", longint'(busy), 0);
      chk("rst done", longint'(done), 0);
      chk("rst fb_we", longint'(fb_we), 0);
      chk("rst zb_re", longint'(zb_re), 0);
      chk("rst zb_we", longint'(zb_we), 0);
      chk("rst frag_count", longint'(frag_count), 0);
      chk("rst fb_xy", longint'({fb_x, fb_y}), 0);
      areset = 1'b0;
      @(posedge clk); #1;

      for (int i = 0; i < 12; i++) run(vt[i], $sformatf("vec%0d", i));

      // back-pressure on the third fragment
      apply(vt[0]);
      b_fb = n_fb;
      for (int i = 0; i < 16; i++) b_hits[i] = hits[i];
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      found = 0;
      for (int i = 0; i < 200 && !found; i++) begin
         @(posedge clk); #1;
         if (fb_we && n_fb - b_fb == 2) found = 1;
      end
      chk("stall third_frag_seen", longint'(found), 1);
      fb_ready = 1'b0;
      sx = fb_x; sy = fb_y; sd = fb_data;
      stable = 1;
      repeat (5) begin
         if (!(fb_we && fb_x == sx && fb_y == sy && fb_data == sd)) stable = 0;
         @(posedge clk); #1;
      end
      fb_ready = 1'b1;
      chk("stall outputs_stable", longint'(stable), 1);
      chk("stall no_write_while_low", n_fb - b_fb, 2);
      wait_done(seen, c, b);
      @(posedge clk); #1;
      chk("stall done", longint'(seen), 1);
      chk("stall fb_writes", n_fb - b_fb, 10);
      chk("stall frag_count", longint'(frag_count), 10);
      perr = 0;
      for (int y = 0; y < 4; y++)
         for (int x = 0; x < 4; x++)
            if (hits[y*4+x] - b_hits[y*4+x] != (in_tri(x, y) ? 1 : 0)) perr++;
      chk("stall pixel_map", perr, 0);

      // reset while scanning, after some fragments have been written
      apply(vt[0]);
      b_fb = n_fb;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      found = 0;
      for (int i = 0; i < 200 && !found; i++) begin
         @(posedge clk); #1;
         if (n_fb - b_fb >= 2 && dut.r_state == S_SCAN) found = 1;
      end
      chk("abort scan_reached", longint'(found), 1);
      areset = 1'b1;
      b_hold = n_fb;
      @(posedge clk); #1;
      chk("abort busy", longint'(busy), 0);
      chk("abort done", longint'(done), 0);
      chk("abort fb_we", longint'(fb_we), 0);
      chk("abort zb_re", longint'(zb_re | zb_we), 0);
      chk("abort frag_count", longint'(frag_count), 0);
      chk("abort addr", longint'({fb_x, fb_y, zb_x, zb_y}), 0);
      @(posedge clk); #1;
      areset = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("abort no_more_writes", n_fb - b_hold, 0);
      run(vt[0], "after_abort");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
